// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the EX stage and the RV32M multi-cycle unit.
// The EX stage drives the master side; the execute unit implements the slave side.
interface muldiv_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] op_a_i;
    logic [XLEN-1:0] op_b_i;
    logic            flush_i;
    logic            busy_o;
    logic            stall_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, funct3_i, op_a_i, op_b_i, flush_i,
        input  busy_o, stall_o, done_o, result_o
    );

    modport slave (
        input  start_i, funct3_i, op_a_i, op_b_i, flush_i,
        output busy_o, stall_o, done_o, result_o
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M execute unit: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with pipeline stall and a one-cycle result pulse.
module muldiv_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input logic               clk,
    input logic               rst_n,
    muldiv_sequencer_if.slave bus
);

    localparam int unsigned CntW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e              state_q;
    logic [2:0]          funct3_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     mag_b_q;
    logic                neg_q;
    logic                sign_a_q;
    logic [CntW-1:0]     cnt_q;
    logic                busy_q;
    logic                done_q;
    logic [XLEN-1:0]     result_q;

    // Start-time decode on the live request
    logic            is_div;
    logic            a_signed;
    logic            b_signed;
    logic            sa;
    logic            sb;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_res;

    always_comb begin
        is_div   = bus.funct3_i[2];
        a_signed = is_div ? ~bus.funct3_i[0] : ~(bus.funct3_i[1] & bus.funct3_i[0]);
        b_signed = is_div ? ~bus.funct3_i[0] : ~bus.funct3_i[1];
        sa       = a_signed & bus.op_a_i[XLEN-1];
        sb       = b_signed & bus.op_b_i[XLEN-1];
        mag_a    = sa ? -bus.op_a_i : bus.op_a_i;
        mag_b    = sb ? -bus.op_b_i : bus.op_b_i;
        div_zero = is_div & (bus.op_b_i == '0);
        div_ovf  = is_div & ~bus.funct3_i[0] & (bus.op_a_i == MinVal) & (bus.op_b_i == '1);
        if (div_zero) begin
            special_res = bus.funct3_i[1] ? bus.op_a_i : '1;
        end else begin
            special_res = bus.funct3_i[1] ? '0 : MinVal;
        end
    end

    // One iteration step. acc_q holds {hi, lo}: for multiply lo is the remaining
    // multiplier and hi the partial product; for divide hi is the partial remainder
    // and lo shifts the dividend out while quotient bits shift in.
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic              div_ok;
    logic [2*XLEN-1:0] acc_next;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
        div_shift = acc_q[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, mag_b_q};
        div_ok    = ~div_diff[XLEN];
        if (funct3_q[2]) begin
            acc_next = {(div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                        acc_q[XLEN-2:0], div_ok};
        end else begin
            acc_next = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        prod_fix = neg_q ? -acc_next : acc_next;
        quo_fix  = neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
        rem_fix  = sign_a_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
        unique case (funct3_q)
            3'b000:                 final_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = quo_fix;
            default:                final_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            funct3_q <= '0;
            acc_q    <= '0;
            mag_b_q  <= '0;
            neg_q    <= 1'b0;
            sign_a_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q   <= 1'b0;
                    result_q <= '0;
                    if (bus.start_i && !bus.flush_i) begin
                        funct3_q <= bus.funct3_i;
                        acc_q    <= {{XLEN{1'b0}}, mag_a};
                        mag_b_q  <= mag_b;
                        neg_q    <= sa ^ sb;
                        sign_a_q <= sa;
                        busy_q   <= 1'b1;
                        if (div_zero || div_ovf) begin
                            state_q  <= StDone;
                            done_q   <= 1'b1;
                            result_q <= special_res;
                        end else begin
                            state_q <= StCalc;
                            cnt_q   <= CntW'(XLEN - 1);
                        end
                    end
                end
                StCalc: begin
                    if (bus.flush_i) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= acc_next;
                        if (cnt_q == '0) begin
                            state_q  <= StDone;
                            done_q   <= 1'b1;
                            result_q <= final_res;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q  <= StIdle;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    result_q <= '0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Stall is low in DONE so EX->MEM captures the result that cycle
    assign bus.stall_o  = ((state_q == StIdle) & bus.start_i & ~bus.flush_i) |
                          (state_q == StCalc);
    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: expected results are queued at issue and
// popped when done_o is observed; latency, stall and flush/reset behaviour checked.
module tb_muldiv_sequencer;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    muldiv_sequencer_if #(.XLEN(32)) bus ();

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_vec = 0;
    int          n_mis = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called just after a clock edge; issues one op and follows it to completion.
    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_cyc);
        int          cyc;
        bit          got;
        bit          run_bad;
        logic [31:0] want;
        bus.funct3_i = f;
        bus.op_a_i   = a;
        bus.op_b_i   = b;
        bus.start_i  = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        check({tag, " stall c0"}, 32'(bus.stall_o), 32'd1);
        check({tag, " busy c0"}, 32'(bus.busy_o), 32'd0);
        @(posedge clk);
        #1;
        bus.start_i  = 1'b0;
        bus.op_a_i   = $urandom();
        bus.op_b_i   = $urandom();
        bus.funct3_i = 3'($urandom_range(0, 7));
        cyc     = 0;
        got     = 1'b0;
        run_bad = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.done_o === 1'b1) got = 1'b1;
            else if (bus.stall_o !== 1'b1 || bus.busy_o !== 1'b1) run_bad = 1'b1;
        end
        want = exp_q.pop_front();
        check({tag, " done seen"}, 32'(got), 32'd1);
        check({tag, " stall/busy in calc"}, 32'(run_bad), 32'd0);
        if (got) begin
            check({tag, " latency"}, 32'(cyc), 32'(exp_cyc));
            check({tag, " result"}, bus.result_o, want);
            check({tag, " stall at done"}, 32'(bus.stall_o), 32'd0);
            check({tag, " busy at done"}, 32'(bus.busy_o), 32'd1);
            @(negedge clk);
            check({tag, " done one-shot"}, 32'(bus.done_o), 32'd0);
            check({tag, " busy after"}, 32'(bus.busy_o), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        rst_n        = 1'b0;
        bus.start_i  = 1'b0;
        bus.flush_i  = 1'b0;
        bus.funct3_i = 3'd0;
        bus.op_a_i   = '0;
        bus.op_b_i   = '0;
        #12;
        check("reset busy", 32'(bus.busy_o), 32'd0);
        check("reset done", 32'(bus.done_o), 32'd0);
        check("reset result", bus.result_o, 32'd0);
        check("reset stall", 32'(bus.stall_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_op("MUL", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        do_op("MULH", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        do_op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        do_op("MULHU", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        do_op("DIV", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        do_op("REM", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        do_op("DIVU", 3'b101, 32'd100, 32'd7, 32'd14, 33);
        do_op("REMU", 3'b111, 32'd100, 32'd7, 32'd2, 33);
        do_op("DIVU/0", 3'b101, 32'd100, 32'd0, 32'hFFFF_FFFF, 1);
        do_op("REM/0", 3'b110, 32'd100, 32'd0, 32'd100, 1);
        do_op("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        for (int i = 0; i < 3; i++) begin
            ra = $urandom();
            rb = $urandom();
            do_op("MUL rnd", 3'b000, ra, rb, ra * rb, 33);
            do_op("MULHU rnd", 3'b011, ra, rb, 32'((64'(ra) * 64'(rb)) >> 32), 33);
            rb = $urandom_range(1, 5000);
            do_op("DIVU rnd", 3'b101, ra, rb, ra / rb, 33);
            do_op("REMU rnd", 3'b111, ra, rb, ra % rb, 33);
        end

        // Start together with flush is dropped
        bus.funct3_i = 3'b000;
        bus.op_a_i   = 32'd3;
        bus.op_b_i   = 32'd5;
        bus.start_i  = 1'b1;
        bus.flush_i  = 1'b1;
        @(negedge clk);
        check("flush+start stall", 32'(bus.stall_o), 32'd0);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        @(negedge clk);
        check("flush+start busy", 32'(bus.busy_o), 32'd0);
        @(posedge clk);
        #1;

        // DIV flushed in cycle 10 while start_i is held high with other operands
        bus.funct3_i = 3'b100;
        bus.op_a_i   = 32'hFFFF_FFF9;
        bus.op_b_i   = 32'd2;
        bus.start_i  = 1'b1;
        @(posedge clk);
        #1;
        bus.funct3_i = 3'b000;
        bus.op_a_i   = 32'd11;
        bus.op_b_i   = 32'd13;
        repeat (9) @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.flush_i = 1'b1;
        @(negedge clk);
        check("flush c10 busy", 32'(bus.busy_o), 32'd1);
        check("flush c10 done", 32'(bus.done_o), 32'd0);
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        do_op("restart DIVU", 3'b101, 32'd100, 32'd7, 32'd14, 33);

        // Reset asserted in cycle 5 of a MUL
        bus.funct3_i = 3'b000;
        bus.op_a_i   = 32'd7;
        bus.op_b_i   = 32'd9;
        bus.start_i  = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst busy", 32'(bus.busy_o), 32'd0);
        check("midrst done", 32'(bus.done_o), 32'd0);
        check("midrst result", bus.result_o, 32'd0);
        check("midrst stall", 32'(bus.stall_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_op("post-reset MUL", 3'b000, 32'h1234_5678, 32'h10, 32'h2345_6780, 33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
